// File: rtl/jtag_host_scan.sv
// JTAG host scan engine: turns TAP-reset / IR-scan / DR-scan / idle commands into TCK/TMS/TDI
// sequences and returns the captured TDO bits. Define JTAG_HOST_CLKDIV_EN to stretch each TCK half-period to CLK_DIV clk cycles.
module jtag_host_scan #(
    parameter int MAX_LEN = 32,
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);
    localparam int         IW      = $clog2(MAX_LEN);
    localparam logic [5:0] LEN_MAX = 6'(MAX_LEN);

    typedef enum logic [1:0] {
        OP_RESET = 2'd0,
        OP_IR    = 2'd1,
        OP_DR    = 2'd2,
        OP_IDLE  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        RESET_SEQ,
        IDLE,
        PRE,
        SHIFT,
        POST,
        RUN,
        DONE
    } state_e;

    state_e             state, state_d;
    op_e                op, op_d;
    logic [5:0]         len, len_d, len_clamped;
    logic [5:0]         cnt, cnt_d, last_cnt;
    logic [MAX_LEN-1:0] data, cap;
    logic               arm_wait;  // one settle cycle after reset release before the first TCK
    logic               tck_d, tms_d, tdi_d;
    logic               accept, active, tick, rise, fall;

    assign cmd_ready = (state == IDLE) || (state == DONE);
    assign busy      = !cmd_ready;
    assign rsp_valid = (state == DONE);
    assign accept    = cmd_valid && cmd_ready;
    assign active    = !arm_wait && (state inside {RESET_SEQ, PRE, SHIFT, POST, RUN});
    assign rise      = active && tick && !tck;
    assign fall      = active && tick && tck;
    assign op_d      = accept ? op_e'(cmd_op) : op;
    assign len_d     = accept ? len_clamped : len;

`ifdef JTAG_HOST_CLKDIV_EN
    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!active || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign tick = (div_cnt == DIV_LAST);
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        if (cmd_len == 6'd0) begin
            len_clamped = 6'd1;
        end else if (cmd_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end else begin
            len_clamped = cmd_len;
        end
    end

    // Index of the final TCK cycle spent in each sequencing state.
    always_comb begin
        last_cnt = 6'd0;
        case (state)
            RESET_SEQ: last_cnt = 6'd5;
            PRE:       last_cnt = (op == OP_IR) ? 6'd3 : 6'd2;
            SHIFT:     last_cnt = len - 6'd1;
            POST:      last_cnt = 6'd1;
            RUN:       last_cnt = (op == OP_RESET) ? 6'd5 : len - 6'd1;
            default:   last_cnt = 6'd0;
        endcase
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d = state;
        cnt_d   = cnt;
        tck_d   = tck;
        case (state)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = (op_d == OP_IR || op_d == OP_DR) ? PRE : RUN;
                    cnt_d   = 6'd0;
                end
            end
            default: begin
                if (rise) begin
                    tck_d = 1'b1;
                end
                if (fall) begin
                    tck_d = 1'b0;
                    if (cnt == last_cnt) begin
                        cnt_d = 6'd0;
                        case (state)
                            RESET_SEQ: state_d = IDLE;
                            PRE:       state_d = SHIFT;
                            SHIFT:     state_d = POST;
                            default:   state_d = DONE;
                        endcase
                    end else begin
                        cnt_d = cnt + 6'd1;
                    end
                end
            end
        endcase
    end

    // TMS/TDI for the TCK cycle about to start; they only move on a tck fall or at acceptance.
    always_comb begin
        tms_d = 1'b0;
        tdi_d = 1'b0;
        case (state_d)
            RESET_SEQ: tms_d = (cnt_d < 6'd5);
            PRE:       tms_d = (op_d == OP_IR) ? (cnt_d < 6'd2) : (cnt_d == 6'd0);
            SHIFT: begin
                tms_d = (cnt_d == len_d - 6'd1);
                tdi_d = data[cnt_d[IW-1:0]];
            end
            POST:      tms_d = (cnt_d == 6'd0);
            RUN:       tms_d = (op_d == OP_RESET) && (cnt_d < 6'd5);
            default:   tms_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RESET_SEQ;
            op       <= OP_RESET;
            len      <= 6'd1;
            cnt      <= 6'd0;
            data     <= '0;
            cap      <= '0;
            rsp_data <= '0;
            arm_wait <= 1'b1;
            tck      <= 1'b0;
            tms      <= 1'b1;
            tdi      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register here samples pre-edge values.
            state    <= state_d;
            cnt      <= cnt_d;
            tck      <= tck_d;
            tms      <= tms_d;
            tdi      <= tdi_d;
            arm_wait <= 1'b0;
            if (accept) begin
                op   <= op_d;
                len  <= len_d;
                data <= cmd_data;
                cap  <= '0;
            end
            if (rise && state == SHIFT) begin
                cap[cnt[IW-1:0]] <= tdo;
            end
            if (state_d == DONE && state != DONE) begin
                rsp_data <= cap;
            end
        end
    end

endmodule
